// File: rtl/dec2to4_dispatch_if.sv
// Request/grant bundle between the encoder-side source,
// the dispatcher and the one-hot consumers.
interface dec2to4_dispatch_if #(
  parameter int CODE_W = 2
);
  localparam int N = 2 ** CODE_W;

  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic [N-1:0]      out_onehot;
  logic              out_ack;
  logic [N-1:0]      pend;
  logic [CODE_W:0]   pend_cnt;
  logic              busy;

  modport master (
    output in_valid,
    output in_code,
    output out_ack,
    input  out_valid,
    input  out_onehot,
    input  pend,
    input  pend_cnt,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  out_ack,
    output out_valid,
    output out_onehot,
    output pend,
    output pend_cnt,
    output busy
  );
endinterface

// File: rtl/dec2to4_dispatch.sv
// Decodes encoded request events into a pending set and
// grants them one at a time, highest index first.
module dec2to4_dispatch #(
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  dec2to4_dispatch_if.slave bus
);
  localparam int N = 2 ** CODE_W;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] oh_q, oh_d;
  logic         vld_q, vld_d;
  logic [N-1:0] sel;
  logic [CODE_W:0] cnt;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) sel = N'(1) << i;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{CODE_W{1'b0}}, pend_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    oh_d    = oh_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          oh_d    = sel;
          vld_d   = 1'b1;
          state_d = PRESENT;
        end else begin
          oh_d  = '0;
          vld_d = 1'b0;
        end
      end
      PRESENT: begin
        if (bus.out_ack) begin
          pend_d  = pend_q & ~oh_q;
          oh_d    = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
    // applied after the ack clear so a colliding set wins
    if (bus.in_valid) pend_d[bus.in_code] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      oh_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      oh_q    <= oh_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.out_onehot = oh_q;
  assign bus.pend       = pend_q;
  assign bus.pend_cnt   = cnt;
  assign bus.busy       = (|pend_q) | vld_q;
endmodule

// File: tb/tb_dec2to4_dispatch.sv
// Scoreboard bench: stimulus queues expected grants,
// a monitor pops them as each new grant appears.
module tb_dec2to4_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;

  dec2to4_dispatch_if #(.CODE_W(2)) bus();

  dec2to4_dispatch #(.CODE_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic prev_v = 1'b0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // monitor: each rising out_valid is one grant
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", {28'd0, bus.out_onehot}, 32'd0);
      end else begin
        chk("grant", {28'd0, bus.out_onehot},
            {28'd0, exp_q.pop_front()});
      end
    end
    prev_v = bus.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(logic [1:0] code);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
  endtask

  task automatic ack_one(logic [2:0] cnt_after);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("ack_wait_timeout", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    chk("cnt_after_ack", {29'd0, bus.pend_cnt},
        {29'd0, cnt_after});
    chk("valid_after_ack", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_code  = 2'd0;
    bus.out_ack  = 1'b0;

    // reset then idle
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_out", {27'd0, bus.out_valid, bus.out_onehot},
          32'd0);
      chk("idle_pend", {27'd0, bus.busy, bus.pend}, 32'd0);
      tick();
    end

    // single request
    enq(2'd2);
    exp_q.push_back(4'b0100);
    tick();
    bus.in_valid = 1'b0;
    chk("single_pend", {28'd0, bus.pend}, 32'h4);
    chk("single_early", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("single_oh", {28'd0, bus.out_onehot}, 32'h4);
    ack_one(3'd0);
    chk("single_pend0", {28'd0, bus.pend}, 32'h0);

    // priority behind a held grant, no preemption
    enq(2'd2);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    tick();
    enq(2'd0);
    tick();
    enq(2'd3);
    tick();
    enq(2'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("prio_cnt4", {29'd0, bus.pend_cnt}, 32'd4);
    chk("prio_nopreempt", {28'd0, bus.out_onehot}, 32'h4);
    ack_one(3'd3);
    ack_one(3'd2);
    ack_one(3'd1);
    ack_one(3'd0);
    chk("prio_busy", {31'd0, bus.busy}, 32'd0);

    // coalescing and hold
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 3; i++) begin
      enq(2'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("coal_cnt", {29'd0, bus.pend_cnt}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_oh", {27'd0, bus.out_valid, bus.out_onehot},
          32'h12);
      tick();
    end
    ack_one(3'd0);
    chk("coal_busy", {31'd0, bus.busy}, 32'd0);

    // same-bit collision of enqueue and ack
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    enq(2'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("coll_pres", {28'd0, bus.out_onehot}, 32'h1);
    bus.out_ack = 1'b1;
    enq(2'd0);
    tick();
    bus.out_ack  = 1'b0;
    bus.in_valid = 1'b0;
    chk("coll_pend", {28'd0, bus.pend}, 32'h1);
    chk("coll_gap", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("coll_repres", {27'd0, bus.out_valid, bus.out_onehot},
        32'h11);
    ack_one(3'd0);

    // async reset mid-present
    exp_q.push_back(4'b1000);
    enq(2'd3);
    tick();
    enq(2'd0);
    tick();
    enq(2'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("mid_pend", {28'd0, bus.pend}, 32'hB);
    chk("mid_oh", {28'd0, bus.out_onehot}, 32'h8);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {27'd0, bus.out_valid, bus.out_onehot},
        32'd0);
    chk("arst_pend", {25'd0, bus.busy, bus.pend_cnt, bus.pend},
        32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
